// File: rtl/rr_arb_mux.sv
// N-way round-robin arbitrated mux with a one-entry registered output buffer.
// Optional multi-beat packet locking is enabled with `define RR_ARB_MUX_LOCK_EN.
module rr_arb_mux #(
  parameter int unsigned nbits = 32,
  parameter int unsigned nreqs = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [nreqs-1:0]              in_val,
  output logic [nreqs-1:0]              in_rdy,
  input  logic [nreqs*nbits-1:0]        in_msg,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [nreqs-1:0]              in_last,
`endif
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [nbits-1:0]              out_msg,
  output logic [$clog2(nreqs)-1:0]      out_sel
);

  localparam int unsigned SELW = $clog2(nreqs);
  localparam int unsigned NR   = nreqs;

  logic            r_out_val;
  logic [nbits-1:0] r_out_msg;
  logic [SELW-1:0] r_out_sel;
  logic [SELW-1:0] r_ptr;

  logic            w_space;
  logic            w_found;
  logic [SELW-1:0] w_gidx;
  logic            w_xfer;
  logic [SELW-1:0] w_ptr_nxt;
  logic            w_adv;

  // Index of the k-th channel after base, wrapping modulo nreqs.
  function automatic logic [SELW-1:0] wrap_idx(input int unsigned base, input int unsigned k);
    int unsigned s;
    s = base + k;
    if (s >= nreqs) s = s - nreqs;
    return SELW'(s);
  endfunction

`ifdef RR_ARB_MUX_LOCK_EN
  logic            r_lock;
  logic [SELW-1:0] r_lidx;
`endif

  // Round-robin search starting at the priority pointer.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int unsigned k = 0; k < nreqs; k++) begin
      if (!w_found && in_val[wrap_idx(32'(r_ptr), k)]) begin
        w_found = 1'b1;
        w_gidx  = wrap_idx(32'(r_ptr), k);
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    // A locked packet owns the output until its last beat.
    if (r_lock) begin
      w_found = in_val[r_lidx];
      w_gidx  = r_lidx;
    end
`endif
  end

  assign w_space   = !r_out_val || out_rdy;
  assign w_xfer    = w_found && w_space && !rst;
  assign in_rdy    = w_xfer ? (NR'(1) << w_gidx) : '0;
  assign w_ptr_nxt = (w_gidx == SELW'(nreqs - 1)) ? '0 : w_gidx + SELW'(1);

`ifdef RR_ARB_MUX_LOCK_EN
  assign w_adv = in_last[w_gidx];
`else
  assign w_adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_val <= 1'b0;
      r_out_msg <= '0;
      r_out_sel <= '0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      r_out_val <= 1'b1;
      r_out_msg <= in_msg[32'(w_gidx)*nbits +: nbits];
      r_out_sel <= w_gidx;
      if (w_adv) r_ptr <= w_ptr_nxt;
    end else if (r_out_val && out_rdy) begin
      r_out_val <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock <= 1'b0;
      r_lidx <= '0;
    end else if (w_xfer) begin
      r_lock <= !in_last[w_gidx];
      if (!in_last[w_gidx]) r_lidx <= w_gidx;
    end
  end
`endif

  assign out_val = r_out_val;
  assign out_msg = r_out_msg;
  assign out_sel = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (4 channels, 32-bit messages).
module tb_rr_arb_mux;

  localparam int unsigned NB = 32;
  localparam int unsigned NR = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    in_val;
  logic [NR-1:0]    in_rdy;
  logic [NR*NB-1:0] in_msg;
  logic [NR-1:0]    in_last;
  logic             out_val;
  logic             out_rdy;
  logic [NB-1:0]    out_msg;
  logic [1:0]       out_sel;

  always #5 clk = ~clk;

  rr_arb_mux #(.nbits(NB), .nreqs(NR)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last(in_last),
`endif
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_sel(out_sel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [NB-1:0] tb_msg [NR];
  logic [NB+1:0] exp_q [$];   // {sel, msg}

  // Reference model state
  logic       m_val;
  logic [1:0] m_ptr;
  logic       m_lock;
  logic [1:0] m_lidx;
  logic [NR-1:0] pend;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 1'b0; m_ptr = 2'd0; m_lock = 1'b0; m_lidx = 2'd0;
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_val = '0; out_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("rdy_in_rst", 64'(in_rdy), 64'(0));
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b0;
    model_reset();
    check_eq("rst_out_val", 64'(out_val), 64'(0));
    check_eq("rst_out_msg", 64'(out_msg), 64'(0));
    check_eq("rst_out_sel", 64'(out_sel), 64'(0));
  endtask

  // One clock: drive at negedge, check, predict, advance to next negedge.
  task automatic cycle(input logic [NR-1:0] val, input logic ordy, input logic [NR-1:0] last);
    logic          space, found;
    logic [1:0]    g, j;
    logic [NR-1:0] exp_rdy;
    logic [NB+1:0] front;
    in_val = val; out_rdy = ordy; in_last = last;
    for (int i = 0; i < NR; i++) in_msg[i*NB +: NB] = tb_msg[i];
    #1;
    space = !m_val || ordy;
    found = 1'b0; g = 2'd0;
    for (int k = 0; k < NR; k++) begin
      j = m_ptr + 2'(k);
      if (!found && val[j]) begin found = 1'b1; g = j; end
    end
    if (m_lock) begin found = val[m_lidx]; g = m_lidx; end
    exp_rdy = (space && found) ? (4'b0001 << g) : 4'b0000;
    check_eq("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    check_eq("out_val", 64'(out_val), 64'(m_val));
    if (m_val) begin
      if (exp_q.size() == 0) begin
        check_eq("queue_empty", 64'(1), 64'(0));
      end else begin
        front = ordy ? exp_q.pop_front() : exp_q[0];
        check_eq("out_msg", 64'(out_msg), 64'(front[NB-1:0]));
        check_eq("out_sel", 64'(out_sel), 64'(front[NB+1:NB]));
      end
    end
    if (m_val && ordy) m_val = 1'b0;
    if (space && found) begin
      exp_q.push_back({g, tb_msg[g]});
      m_val = 1'b1;
      pend[g] = 1'b0;
`ifdef RR_ARB_MUX_LOCK_EN
      if (!last[g]) begin m_lock = 1'b1; m_lidx = g; end
      else begin m_lock = 1'b0; m_ptr = g + 2'd1; end
`else
      m_ptr = g + 2'd1;
`endif
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_val = '0; out_rdy = 1'b0; in_msg = '0; in_last = '1; pend = '0;
    for (int i = 0; i < NR; i++) tb_msg[i] = 32'h100 + 32'(i);
    model_reset();
    @(negedge clk);

    // Reset then idle
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, 1'b1, 4'b1111);
      check_eq("idle_msg", 64'(out_msg), 64'(0));
    end

    // Single channel, full throughput
    tb_msg[2] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) cycle(4'b0100, 1'b1, 4'b1111);
    cycle(4'b0000, 1'b1, 4'b1111);
    tb_msg[2] = 32'h102;

    // All channels: grants from ptr=3 wrap through 3,0,1,2,3,0...
    for (int i = 0; i < 9; i++) cycle(4'b1111, 1'b1, 4'b1111);
    cycle(4'b0000, 1'b1, 4'b1111);

    // Backpressure then same-cycle drain and refill
    cycle(4'b0010, 1'b1, 4'b1111);
    for (int i = 0; i < 5; i++) cycle(4'b1000, 1'b0, 4'b1111);
    cycle(4'b1000, 1'b1, 4'b1111);
    check_eq("refill_sel", 64'(out_sel), 64'(3));
    cycle(4'b0000, 1'b1, 4'b1111);

    // Reset with a full buffer holding ch2
    cycle(4'b0100, 1'b1, 4'b1111);
    cycle(4'b0000, 1'b0, 4'b1111);
    check_eq("pre_rst_sel", 64'(out_sel), 64'(2));
    do_reset(1);
    cycle(4'b1111, 1'b1, 4'b1111);
    check_eq("post_rst_grant", 64'(out_sel), 64'(0));
    cycle(4'b0000, 1'b1, 4'b1111);

    // Random traffic; requests held until granted
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < NR; c++) tb_msg[c] = $urandom;
      pend = pend | 4'($urandom_range(0, 15));
      cycle(pend, 1'($urandom_range(0, 3) != 0), 4'b1111);
    end
    pend = '0;
    cycle(4'b0000, 1'b1, 4'b1111);
    cycle(4'b0000, 1'b1, 4'b1111);

`ifdef RR_ARB_MUX_LOCK_EN
    // Locked 3-beat packet from ch1 while ch0 and ch2 contend
    do_reset(1);
    for (int i = 0; i < NR; i++) tb_msg[i] = 32'h200 + 32'(i);
    cycle(4'b0001, 1'b1, 4'b1111);
    cycle(4'b0111, 1'b1, 4'b1101);
    check_eq("lock_sel0", 64'(out_sel), 64'(1));
    cycle(4'b0111, 1'b1, 4'b1101);
    check_eq("lock_sel1", 64'(out_sel), 64'(1));
    cycle(4'b0111, 1'b1, 4'b1111);
    check_eq("lock_sel2", 64'(out_sel), 64'(1));
    cycle(4'b0101, 1'b1, 4'b1111);
    check_eq("lock_after2", 64'(out_sel), 64'(2));
    cycle(4'b0001, 1'b1, 4'b1111);
    check_eq("lock_after0", 64'(out_sel), 64'(0));
    cycle(4'b0000, 1'b1, 4'b1111);
`endif

    check_eq("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
